quad_decoder: RTL and testbench

- Parametrised quadrature encoder interface for motor feedback.
- Synchronises and glitch-filters the A/B/index inputs, then decodes 4x to a WIDTH-bit position counter.
- Adds index-zeroing, position preload, illegal-transition detection and optional velocity measurement.
- Sits between the encoder pins and the motor control/register logic.

---
 rtl/quad_decoder.sv | 198 +++++++++++++++++++
 tb/tb_quad_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front end for motor feedback.
// Synchronises and glitch-filters A/B/index, decodes 4x into a wrapping
// WIDTH-bit position counter, with index zeroing, preload and
// illegal-transition detection.
// Optional velocity measurement is built when QUAD_VELOCITY_EN is defined;
// otherwise vel/vel_valid are tied to 0.
// Ports:
//   clk, resetn          clock, async active-low reset
//   quadA, quadB, index  asynchronous encoder pins
//   index_en             allow filtered index rising edge to zero count
//   load, load_val       synchronous preload of count (highest priority)
//   err_clr              clears sticky err (a new illegal event wins)
//   count, dir, step     position, last direction (1=up), step pulse
//   err, index_seen      sticky illegal flag, sticky index-zeroed flag
//   vel, vel_valid       signed steps per window, update pulse
module quad_decoder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned VEL_PERIOD  = 1000,
  parameter int unsigned VEL_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 quadA,
  input  logic                 quadB,
  input  logic                 index,
  input  logic                 index_en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 dir,
  output logic                 step,
  output logic                 err,
  output logic                 index_seen,
  output logic [VEL_WIDTH-1:0] vel,
  output logic                 vel_valid
);

  // Channel order inside all per-channel vectors: [0]=A, [1]=B, [2]=index.
  localparam int unsigned NCH   = 3;
  localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // Elaboration-time parameter sanity check.
  if (WIDTH < 2 || SYNC_STAGES < 2 || FILTER_LEN < 1 ||
      VEL_PERIOD < 2 || VEL_WIDTH < 2) begin : g_param_check
    $error("quad_decoder: illegal parameter value");
  end

  logic [NCH-1:0]             pins;
  logic [SYNC_STAGES*NCH-1:0] sync_q, sync_d;
  logic [NCH-1:0]             sync_out;
  logic [NCH-1:0]             filt_q, filt_d;
  logic [NCH-1:0][RUN_W-1:0]  run_q, run_d;
  logic [NCH-1:0]             cur_q, cur_d;
  logic [NCH-1:0]             prev_q, prev_d;
  logic [WIDTH-1:0]           count_q, count_d;
  logic                       dir_q, dir_d;
  logic                       step_q, step_d;
  logic                       err_q, err_d;
  logic                       seen_q, seen_d;
  logic                       a_chg, b_chg, step_c, illegal_c, up_c, idx_rise_c;

  assign pins     = {index, quadB, quadA};
  assign sync_out = sync_q[SYNC_STAGES*NCH-1 -: NCH];

  // Synchroniser shift and per-channel run-length filter.
  always_comb begin
    sync_d = {sync_q[(SYNC_STAGES-1)*NCH-1:0], pins};
    filt_d = filt_q;
    run_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync_out[i] != filt_q[i]) begin
        if (run_q[i] == RUN_W'(FILTER_LEN - 1)) filt_d[i] = sync_out[i];
        else                                    run_d[i]  = run_q[i] + RUN_W'(1);
      end
    end
  end

  // Decode stage compares the registered filtered level with its previous value.
  assign a_chg      = cur_q[0] ^ prev_q[0];
  assign b_chg      = cur_q[1] ^ prev_q[1];
  assign step_c     = a_chg ^ b_chg;
  assign illegal_c  = a_chg & b_chg;
  assign up_c       = cur_q[0] ^ prev_q[1];
  assign idx_rise_c = cur_q[2] & ~prev_q[2];

  // Position, direction, error and index bookkeeping.
  always_comb begin
    cur_d   = filt_q;
    prev_d  = cur_q;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = step_c;
    err_d   = err_q;
    seen_d  = seen_q;
    if (step_c) dir_d = up_c;
    if (illegal_c)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    if (load) begin
      count_d = load_val;
      seen_d  = 1'b0;
    end else if (idx_rise_c && index_en) begin
      count_d = '0;
      seen_d  = 1'b1;
    end else if (step_c) begin
      count_d = up_c ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      filt_q  <= '0;
      run_q   <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      filt_q  <= filt_d;
      run_q   <= run_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign err        = err_q;
  assign index_seen = seen_q;

`ifdef QUAD_VELOCITY_EN
  localparam int unsigned WIN_W = $clog2(VEL_PERIOD);
  localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic [WIN_W-1:0]     win_q, win_d;
  logic [VEL_WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                 vv_q, vv_d;
  logic                 win_end;

  // Saturating signed step accumulator over a free-running window.
  always_comb begin
    acc_step = acc_q;
    if (step_c) begin
      if (up_c) begin
        if (acc_q != VEL_MAX) acc_step = acc_q + VEL_WIDTH'(1);
      end else begin
        if (acc_q != VEL_MIN) acc_step = acc_q - VEL_WIDTH'(1);
      end
    end
    win_end = (win_q == WIN_W'(VEL_PERIOD - 1));
    win_d   = win_end ? '0 : win_q + WIN_W'(1);
    acc_d   = acc_step;
    vel_d   = vel_q;
    vv_d    = 1'b0;
    if (win_end) begin
      vel_d = acc_step;
      vv_d  = 1'b1;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q <= '0;
      acc_q <= '0;
      vel_q <= '0;
      vv_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      acc_q <= acc_d;
      vel_q <= vel_d;
      vv_q  <= vv_d;
    end
  end

  assign vel       = vel_q;
  assign vel_valid = vv_q;
`else
  assign vel       = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (default parameters).
// Inputs are driven just after a falling edge and outputs sampled on falling
// edges, so a change driven at negedge N is first sampled by the next posedge
// and a 7-edge latency shows up at negedge N+8.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        quadA, quadB, index, index_en, load, err_clr;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        dir, step, err, index_seen;
  logic [11:0] vel;
  logic        vel_valid;

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  int vv_cnt   = 0;
  int g = 0;
  int s0;

  quad_decoder dut (
    .clk       (clk),
    .resetn    (resetn),
    .quadA     (quadA),
    .quadB     (quadB),
    .index     (index),
    .index_en  (index_en),
    .load      (load),
    .load_val  (load_val),
    .err_clr   (err_clr),
    .count     (count),
    .dir       (dir),
    .step      (step),
    .err       (err),
    .index_seen(index_seen),
    .vel       (vel),
    .vel_valid (vel_valid)
  );

  always #5 clk = ~clk;

  // Pulse counters, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (step)      step_cnt = step_cnt + 1;
    if (vel_valid) vv_cnt   = vv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Quadrature phase table, {A,B}; increasing index = A leads B (up).
  function automatic logic [1:0] ab_of(input int ph);
    logic [1:0] sel;
    sel = 2'(ph);
    case (sel)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic drive_phase(input int ph);
    {quadA, quadB} = ab_of(ph);
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

`ifdef QUAD_VELOCITY_EN
  task automatic wait_vel_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (vel_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask
`endif

  initial begin
    resetn = 1'b0; quadA = 1'b0; quadB = 1'b0; index = 1'b0;
    index_en = 1'b0; load = 1'b0; load_val = '0; err_clr = 1'b0;
    wait_neg(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dir",   32'(dir),   32'd0);
    check("rst_step",  32'(step),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_seen",  32'(index_seen), 32'd0);
    check("rst_vel",   32'(vel),   32'd0);
    check("rst_vv",    32'(vel_valid), 32'd0);
    resetn = 1'b1;
    wait_neg(5);
    check("idle_count", 32'(count), 32'd0);

    // 8 forward cycles, 20 clk per phase; first step latency checked exactly.
    for (int i = 0; i < 32; i++) begin
      g = g + 1;
      drive_phase(g);
      if (i == 0) begin
        wait_neg(7);
        check("lat_before_cnt",  32'(count), 32'd0);
        check("lat_before_step", 32'(step),  32'd0);
        wait_neg(1);
        check("lat_at_cnt",  32'(count), 32'd1);
        check("lat_at_step", 32'(step),  32'd1);
        wait_neg(12);
      end else begin
        wait_neg(20);
      end
    end
    check("fwd_count", 32'(count), 32'd32);
    check("fwd_steps", 32'(step_cnt), 32'd32);
    check("fwd_dir",   32'(dir),   32'd1);
    check("fwd_err",   32'(err),   32'd0);

    // Wrap down from 0 and back up.
    do_load(16'h0000);
    check("load0", 32'(count), 32'd0);
    g = g - 1;
    drive_phase(g);
    wait_neg(20);
    check("rev_wrap_cnt", 32'(count), 32'h0000_FFFF);
    check("rev_wrap_dir", 32'(dir),   32'd0);
    g = g + 1;
    drive_phase(g);
    wait_neg(20);
    check("fwd_wrap_cnt", 32'(count), 32'd0);
    check("fwd_wrap_dir", 32'(dir),   32'd1);

    // Glitch rejection then a minimum-length accepted pulse (up then down).
    s0 = step_cnt;
    quadA = 1'b1; wait_neg(2); quadA = 1'b0;
    wait_neg(15);
    check("glitch_steps", 32'(step_cnt - s0), 32'd0);
    check("glitch_cnt",   32'(count), 32'd0);
    quadA = 1'b1; wait_neg(4); quadA = 1'b0;
    wait_neg(20);
    check("pulse_steps", 32'(step_cnt - s0), 32'd2);
    check("pulse_cnt",   32'(count), 32'd0);
    check("pulse_dir",   32'(dir),   32'd0);

    // Illegal double transition 00 -> 11.
    s0 = step_cnt;
    quadA = 1'b1; quadB = 1'b1;
    wait_neg(12);
    check("ill_err",   32'(err),   32'd1);
    check("ill_cnt",   32'(count), 32'd0);
    check("ill_steps", 32'(step_cnt - s0), 32'd0);
    check("ill_dir",   32'(dir),   32'd0);
    err_clr = 1'b1; wait_neg(1); err_clr = 1'b0;
    check("errclr", 32'(err), 32'd0);
    // Second illegal event 11 -> 00 arrives with err_clr in the same cycle.
    quadA = 1'b0; quadB = 1'b0;
    wait_neg(7);
    check("ill2_pre", 32'(err), 32'd0);
    err_clr = 1'b1; wait_neg(1); err_clr = 1'b0;
    check("ill2_setwins", 32'(err), 32'd1);
    check("ill2_cnt",     32'(count), 32'd0);
    g = 0;

    // Counting continues while err is set.
    g = g + 1;
    drive_phase(g);
    wait_neg(20);
    check("err_count", 32'(count), 32'd1);

    // Index zeroing coincident with an up step.
    do_load(16'd100);
    check("load100", 32'(count), 32'd100);
    index_en = 1'b1;
    g = g + 1;
    drive_phase(g);
    index = 1'b1;
    wait_neg(7);
    check("idx_pre_cnt", 32'(count), 32'd100);
    wait_neg(1);
    check("idx_cnt",  32'(count), 32'd0);
    check("idx_seen", 32'(index_seen), 32'd1);
    check("idx_step", 32'(step), 32'd1);
    check("idx_dir",  32'(dir), 32'd1);
    index = 1'b0;
    wait_neg(20);
    check("idx_fall_cnt", 32'(count), 32'd0);

    // Load coincident with an index zeroing: load wins and clears index_seen.
    index = 1'b1;
    wait_neg(7);
    check("ld_idx_pre_seen", 32'(index_seen), 32'd1);
    load = 1'b1; load_val = 16'h1234;
    wait_neg(1);
    load = 1'b0;
    check("ld_idx_cnt",  32'(count), 32'h1234);
    check("ld_idx_seen", 32'(index_seen), 32'd0);
    wait_neg(20);
    check("ld_idx_hold", 32'(count), 32'h1234);

    // Index ignored when disabled.
    index_en = 1'b0;
    index = 1'b0; wait_neg(20);
    index = 1'b1; wait_neg(20);
    check("idx_dis_cnt",  32'(count), 32'h1234);
    check("idx_dis_seen", 32'(index_seen), 32'd0);

`ifdef QUAD_VELOCITY_EN
    // Align to a window boundary, then 25 up and 10 down steps.
    wait_vel_valid("vel_sync");
    for (int i = 0; i < 25; i++) begin
      g = g + 1; drive_phase(g); wait_neg(10);
    end
    for (int i = 0; i < 10; i++) begin
      g = g - 1; drive_phase(g); wait_neg(10);
    end
    wait_vel_valid("vel_win1");
    check("vel_15", 32'(vel), 32'd15);
    wait_vel_valid("vel_win2");
    check("vel_idle", 32'(vel), 32'd0);
`else
    check("novel_vv_cnt", 32'(vv_cnt), 32'd0);
    check("novel_vel",    32'(vel),    32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
